// File: rtl/mac_result_drain_if.sv
// Output handshake between the result drain and the output writer.
interface mac_result_drain_if #(
  parameter int OUT_WIDTH = 16
);
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/mac_result_drain.sv
// Snapshots a free-running MAC accumulator at window boundaries and queues
// the scaled, saturated per-window sums behind a valid/ready handshake.
module mac_result_drain #(
  parameter int IMG_WIDTH   = 16,
  parameter int KER_WIDTH   = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int MAC_LATENCY = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           val,
  input  logic                           last,
  input  logic [4:0]                     cfg_shift,
  input  logic [IMG_WIDTH+KER_WIDTH:0]   result,
  mac_result_drain_if.master             drain,
  output logic                           overflow
);
  localparam int ACC_W = IMG_WIDTH + KER_WIDTH + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Window markers travel alongside the MAC pipeline; no stall.
  logic       dl_mark  [MAC_LATENCY];
  logic [4:0] dl_shift [MAC_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAC_LATENCY; i++) begin
        dl_mark[i]  <= 1'b0;
        dl_shift[i] <= '0;
      end
    end else begin
      dl_mark[0]  <= val & last;
      dl_shift[0] <= cfg_shift;
      for (int unsigned i = 1; i < MAC_LATENCY; i++) begin
        dl_mark[i]  <= dl_mark[i-1];
        dl_shift[i] <= dl_shift[i-1];
      end
    end
  end

  logic             cap_v;
  logic [ACC_W-1:0] prev;
  logic [ACC_W-1:0] delta;
  logic [4:0]       cap_shift;

  // Modular difference keeps window sums correct across accumulator wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_v     <= 1'b0;
      prev      <= '0;
      delta     <= '0;
      cap_shift <= '0;
    end else begin
      cap_v <= dl_mark[MAC_LATENCY-1];
      if (dl_mark[MAC_LATENCY-1]) begin
        delta     <= result - prev;
        prev      <= result;
        cap_shift <= dl_shift[MAC_LATENCY-1];
      end
    end
  end

  logic signed [ACC_W-1:0] shifted;
  logic [OUT_WIDTH-1:0]    sat;

  always_comb begin
    shifted = $signed(delta) >>> cap_shift;
    if (shifted > SAT_MAX)      sat = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) sat = SAT_MIN[OUT_WIDTH-1:0];
    else                        sat = shifted[OUT_WIDTH-1:0];
  end

  logic                 wr_req;
  logic [OUT_WIDTH-1:0] wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_req  <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_req  <= cap_v;
      wr_data <= sat;
    end
  end

  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]        count, remain, count_next;
  logic                 rd, wr, drop;

  always_comb begin
    rd         = drain.out_valid & drain.out_ready;
    wr         = wr_req & ((count != FULL) | rd);
    drop       = wr_req & ~wr;
    rd_next    = rd_ptr + AW'(rd);
    remain     = count - CW'(rd);
    count_next = remain + CW'(wr);
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  // Head register is loaded from the post-update queue so out_data is valid with out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      drain.out_valid <= 1'b0;
      drain.out_data  <= '0;
      overflow        <= 1'b0;
    end else begin
      rd_ptr          <= rd_next;
      if (wr) wr_ptr  <= wr_ptr + AW'(1);
      count           <= count_next;
      drain.out_valid <= count_next != '0;
      drain.out_data  <= (remain == '0) ? wr_data : mem[rd_next];
      if (drop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: behavioural MAC drives result; expected words
// come from window sums computed with plain arithmetic.
module tb_mac_result_drain;
  logic              clk = 1'b0;
  logic              rst;
  logic              val;
  logic              last;
  logic [4:0]        cfg_shift;
  logic [32:0]       result;
  logic              overflow;
  logic signed [15:0] img, ker;

  logic rdy_mode, rdy_manual, rnd_bit;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   exp_q[$];
  int   pop_cyc[$];
  longint win_sum = 0;
  bit   suppress = 1'b0;

  mac_result_drain_if #(.OUT_WIDTH(16)) drain ();

  mac_result_drain #(
    .IMG_WIDTH(16), .KER_WIDTH(16), .OUT_WIDTH(16), .MAC_LATENCY(5), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .val(val), .last(last), .cfg_shift(cfg_shift),
    .result(result), .drain(drain.master), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign drain.out_ready = rdy_mode ? (rnd_bit | cyc[0]) : rdy_manual;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rnd_bit <= 1'($urandom);
  end

  // Paired MAC: accumulate at the beat edge, visible on result 4 edges later.
  logic [32:0] acc;
  logic [32:0] pipe [4];
  logic signed [32:0] prod;
  assign prod   = 33'(img) * 33'(ker);
  assign result = pipe[3];

  always @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      for (int i = 0; i < 4; i++) pipe[i] <= '0;
    end else begin
      if (val) acc <= acc + prod;
      pipe[0] <= acc;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_word(input longint s, input int sh);
    longint v;
    v = s >>> sh;
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  always @(negedge clk) begin
    if (!rst && drain.out_valid && drain.out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_word observed=%0d expected=none", $signed(drain.out_data));
      end
      if (exp_q.size() != 0) check("out_data", longint'($signed(drain.out_data)), exp_q.pop_front());
      pop_cyc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      val  = 1'b0;
      last = 1'($urandom);
      img  = 16'($urandom);
      ker  = 16'($urandom);
      @(posedge clk); #1;
    end
    last = 1'b0;
  endtask

  task automatic send_beat(input int a, input int b, input bit lst, input int sh);
    img = 16'(a); ker = 16'(b); val = 1'b1; last = lst; cfg_shift = 5'(sh);
    win_sum += longint'(a) * longint'(b);
    if (lst) begin
      if (!suppress) exp_q.push_back(ref_word(win_sum, sh));
      win_sum = 0;
    end
    @(posedge clk); #1;
    val = 1'b0; last = 1'b0; cfg_shift = 5'($urandom);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1; val = 1'($urandom); last = 1'($urandom);
      img = 16'($urandom); ker = 16'($urandom); cfg_shift = 5'($urandom);
      @(posedge clk); #1;
      check("rst_out_valid", longint'(drain.out_valid), 0);
      check("rst_out_data", longint'(drain.out_data), 0);
      check("rst_overflow", longint'(overflow), 0);
    end
    rst = 1'b0; val = 1'b0; last = 1'b0;
    exp_q.delete(); win_sum = 0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !drain.out_valid) break;
      @(posedge clk); #1;
    end
    check("drain_pending", longint'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sh;
    rst = 1'b1; val = 1'b0; last = 1'b0; cfg_shift = '0; img = '0; ker = '0;
    rdy_mode = 1'b0; rdy_manual = 1'b1;
    @(negedge clk);
    do_reset(2);
    idle(3);

    // Single 4-beat window and its latency from the last edge.
    for (int i = 0; i < 3; i++) send_beat(3, 4, 1'b0, 0);
    send_beat(3, 4, 1'b1, 0);
    repeat (6) @(posedge clk);
    #1 check("latency_pre", longint'(drain.out_valid), 0);
    @(posedge clk); #1;
    check("latency_hit", longint'(drain.out_valid), 1);
    check("single_head", longint'($signed(drain.out_data)), 48);
    wait_drain(50);

    // Back-to-back windows with last on consecutive cycles.
    pop_cyc.delete();
    for (int i = 0; i < 3; i++) send_beat(3, 4, 1'b0, 0);
    send_beat(3, 4, 1'b1, 0);
    send_beat(-2, 5, 1'b1, 0);
    wait_drain(50);
    check("b2b_count", longint'(pop_cyc.size()), 2);
    if (pop_cyc.size() == 2) check("b2b_spacing", longint'(pop_cyc[1] - pop_cyc[0]), 1);

    // Scaling and saturation corners.
    send_beat(32767, 32767, 1'b1, 0);
    send_beat(-32768, 32767, 1'b1, 0);
    send_beat(10, 16, 1'b1, 4);
    send_beat(-17, 1, 1'b1, 2);
    send_beat(-1, 1, 1'b1, 31);
    wait_drain(50);
    check("ovf_clear", longint'(overflow), 0);

    // Backpressure: queue of 4 fills, 5th word dropped.
    rdy_manual = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      suppress = (k == 5);
      send_beat(k, 1, 1'b1, 0);
    end
    suppress = 1'b0;
    idle(12);
    check("bp_overflow", longint'(overflow), 1);
    check("bp_valid", longint'(drain.out_valid), 1);
    check("bp_head", longint'($signed(drain.out_data)), 1);
    rdy_manual = 1'b1;
    wait_drain(50);
    check("bp_empty", longint'(drain.out_valid), 0);
    do_reset(1);

    // Reset two cycles after last discards the in-flight window.
    suppress = 1'b1;
    send_beat(1, 1, 1'b0, 0);
    send_beat(1, 1, 1'b1, 0);
    suppress = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; win_sum = 0;
    idle(20);
    check("midrst_valid", longint'(drain.out_valid), 0);
    send_beat(2, 3, 1'b1, 0);
    wait_drain(50);

    // Random windows against random but bounded-rate backpressure.
    rdy_mode = 1'b1;
    for (int w = 0; w < 40; w++) begin
      n  = $urandom_range(6, 3);
      sh = ($urandom_range(3, 0) == 0) ? $urandom_range(31, 0) : $urandom_range(8, 0);
      for (int b = 0; b < n; b++)
        send_beat(int'($urandom_range(65535, 0)) - 32768,
                  int'($urandom_range(65535, 0)) - 32768, b == n - 1, sh);
      idle($urandom_range(2, 0));
    end
    wait_drain(400);
    rdy_mode = 1'b0;
    check("rand_overflow", longint'(overflow), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
